cpu_ctrl_fsm: RTL
=================

# cpu_ctrl_fsm

Multi-cycle control state machine for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath selects: the imm_gen type select, ALU operand muxes, PC source and writeback source. It also drives the register, PC and IR write strobes and the memory request handshake. Illegal opcodes and memory timeouts put the block into a sticky fault state.

## Interface
- TIMEOUT_CYCLES, 255, consecutive un-acked memory-request cycles that trigger a fault (must be ≥1)
- clk_w_i  in  1  clock; all state updates on the rising edge
- rst_w_i  in  1  reset, synchronous, active-high
- instr_w_i  in  32  IR contents; valid from DECODE onward
- br_taken_w_i  in  1  branch comparator result; sampled in EXEC
- mem_ready_w_i  in  1  memory acknowledge for the current request
- mem_req_w_o  out  1  memory request
- mem_we_w_o  out  1  store when 1, read when 0
- ir_we_w_o  out  1  IR load strobe
- pc_we_w_o  out  1  PC write strobe
- pc_src_w_o  out  2  PC source: 0 = pc+4, 1 = ALU result, 2 = ALU result & ~1
- imm_sel_w_o  out  3  imm_gen type: 0 = none, 1 = J, 2 = U, 3 = S, 4 = B, 5 = I
- alu_a_sel_w_o  out  1  ALU A operand: 0 = rs1, 1 = PC
- alu_b_sel_w_o  out  1  ALU B operand: 0 = rs2, 1 = immediate
- alu_add_w_o  out  1  forces ALU ADD (address and target calculation)
- wb_sel_w_o  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = pc+4
- reg_we_w_o  out  1  register file write strobe
- fault_w_o  out  1  sticky fault flag
- state_w_o  out  3  current state, for debug

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7.
- Legal opcodes (instr[6:0]): LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- **FETCH**
  - mem_req = 1, mem_we = 0.
  - On mem_ready: ir_we = 1 in that same cycle, then go to DECODE.
- **DECODE**
  - Illegal opcode: go to FAULT.
  - Otherwise: go to EXEC.
- **EXEC** (operand selects by class)
  - AUIPC, JAL, BRANCH: a = PC, b = imm, add = 1.
  - JALR, LOAD, STORE, OP-IMM: a = rs1, b = imm; add = 1 except for OP-IMM.
  - OP: a = rs1, b = rs2.
  - LUI: b = imm, add = 1; the ALU A input is zeroed by the datapath when opcode = LUI.
- **EXEC next state**
  - BRANCH: pc_we = 1, pc_src = 1 if br_taken else 0, then go to FETCH.
  - LOAD, STORE: go to MEM.
  - All others: go to WB.
- **MEM**
  - mem_req = 1, mem_we = 1 for STORE only.
  - On mem_ready, STORE: pc_we = 1, pc_src = 0, then go to FETCH.
  - On mem_ready, LOAD: go to WB.
- **WB**
  - reg_we = 1 unless instr[11:7] = 0.
  - pc_we = 1; pc_src = 1 for JAL, 2 for JALR, 0 otherwise.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - Then go to FETCH.
- imm_sel is decoded from the opcode in DECODE, EXEC, MEM and WB, and is 0 in FETCH and FAULT.
  - J: JAL. U: LUI, AUIPC. S: STORE. B: BRANCH. I: JALR, LOAD, OP-IMM. OP: 0.
- **Timeout**
  - The wait counter increments on each FETCH/MEM cycle with mem_req = 1 and mem_ready = 0.
  - It clears on any state change.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - If the counter reaches TIMEOUT_CYCLES-1 and mem_ready = 0, go to FAULT.
  - mem_ready in the final allowed cycle wins over the timeout.
- **FAULT**
  - All strobes and mem_req are 0; fault = 1.
  - Held until reset.
- mem_ready is ignored whenever mem_req = 0.

## Timing
- State, wait counter and fault are registered. All other outputs are combinational from state, instr_w_i, mem_ready_w_i and br_taken_w_i.
- Reset values: state = FETCH, counter = 0, fault = 0.
- While rst_w_i = 1, every output is forced to 0, including mem_req. This holds even mid-request; the memory is expected to drop the transaction.
- Cycles per instruction with zero-wait memory:
  - BRANCH: 3.
  - STORE: 4.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
- Each memory wait cycle adds 1 cycle.
- ir_we and the mem_ready-qualified pc_we are single-cycle pulses, coincident with the accepting mem_ready.
- Entry into FAULT takes effect at the next clock edge after the detecting cycle.

## Structure
- Shared include cpu_defs.vh holds: opcode localparams, imm type codes (J = 1, U = 2, S = 3, B = 4, I = 5, shared with imm_gen and its bench), state encodings, and pc_src / wb_sel codes.
- Sub-module ctrl_decode: combinational opcode classifier producing legal, class one-hot and imm_sel. The FSM instantiates it once.

## Test plan
- Reset held for 2 cycles, then released with mem_ready = 1 and IR = ADDI 0x00500093:
  - FETCH → DECODE → EXEC → WB → FETCH over 4 cycles.
  - imm_sel = 5, alu_b_sel = 1, reg_we = 1 in WB.
- LW 0x0000A103 with mem_ready low for 3 MEM cycles:
  - mem_req high for 4 MEM cycles.
  - WB has wb_sel = 1.
  - Total 8 cycles.
- BEQ 0x00000463 with br_taken = 1, then br_taken = 0:
  - imm_sel = 4.
  - pc_we in EXEC, pc_src = 1, then 0.
  - No WB state and no reg_we.
- JALR 0x000080E7:
  - imm_sel = 5, pc_src = 2, wb_sel = 2, reg_we = 1.
  - LUI with rd = 0 (0x00001037) gives reg_we = 0.
- IR = 0xFFFFFFFF: FAULT after DECODE, fault_w_o = 1 and held; all strobes 0 until reset.
- TIMEOUT_CYCLES = 4:
  - mem_ready never asserted in FETCH: FAULT after 4 request cycles.
  - mem_ready on the 4th cycle: proceeds to DECODE.
  - rst asserted mid-MEM: mem_req = 0 immediately and state = FETCH next cycle.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared control definitions for the RV32I multi-cycle core: opcodes,
// imm_gen type codes, FSM state encodings, PC/writeback source codes and
// the opcode class record produced by the decoder.
package cpu_ctrl_fsm_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // imm_gen type select, shared with imm_gen
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_J    = 3'd1;
  localparam logic [2:0] IMM_U    = 3'd2;
  localparam logic [2:0] IMM_S    = 3'd3;
  localparam logic [2:0] IMM_B    = 3'd4;
  localparam logic [2:0] IMM_I    = 3'd5;

  localparam logic [1:0] PC_PLUS4     = 2'd0;
  localparam logic [1:0] PC_ALU       = 2'd1;
  localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  // One-hot opcode class; all zero means illegal opcode
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
  } opc_class_t;

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational opcode classifier.
// Ports: opcode_i (instr[6:0]) -> legal_o, cls_o (class one-hot), imm_sel_o.
module cpu_ctrl_fsm_decode
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             legal_o,
  output opc_class_t       cls_o,
  output logic [2:0]       imm_sel_o
);

  always_comb begin
    cls_o     = '0;
    imm_sel_o = IMM_NONE;
    case (opcode_i)
      OPC_LUI:    begin cls_o.lui    = 1'b1; imm_sel_o = IMM_U; end
      OPC_AUIPC:  begin cls_o.auipc  = 1'b1; imm_sel_o = IMM_U; end
      OPC_JAL:    begin cls_o.jal    = 1'b1; imm_sel_o = IMM_J; end
      OPC_JALR:   begin cls_o.jalr   = 1'b1; imm_sel_o = IMM_I; end
      OPC_BRANCH: begin cls_o.branch = 1'b1; imm_sel_o = IMM_B; end
      OPC_LOAD:   begin cls_o.load   = 1'b1; imm_sel_o = IMM_I; end
      OPC_STORE:  begin cls_o.store  = 1'b1; imm_sel_o = IMM_S; end
      OPC_OP_IMM: begin cls_o.op_imm = 1'b1; imm_sel_o = IMM_I; end
      OPC_OP:     begin cls_o.op     = 1'b1; end
      default:    ;
    endcase
    legal_o = |cls_o;
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky FAULT
// on illegal opcode or memory request timeout.
// Inputs : clk_w_i, rst_w_i (sync, active-high), instr_w_i, br_taken_w_i,
//          mem_ready_w_i.
// Outputs: memory handshake (mem_req/mem_we), IR/PC/RF strobes, datapath
//          selects (pc_src, imm_sel, alu_a/b_sel, alu_add, wb_sel),
//          fault flag and debug state. State, wait counter and fault are
//          registered; everything else is combinational and forced to 0
//          while reset is asserted.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i,
  input  logic [31:0] instr_w_i,
  input  logic        br_taken_w_i,
  input  logic        mem_ready_w_i,
  output logic        mem_req_w_o,
  output logic        mem_we_w_o,
  output logic        ir_we_w_o,
  output logic        pc_we_w_o,
  output logic [1:0]  pc_src_w_o,
  output logic [2:0]  imm_sel_w_o,
  output logic        alu_a_sel_w_o,
  output logic        alu_b_sel_w_o,
  output logic        alu_add_w_o,
  output logic [1:0]  wb_sel_w_o,
  output logic        reg_we_w_o,
  output logic        fault_w_o,
  output logic [2:0]  state_w_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic             legal;
  opc_class_t       cls;
  logic [2:0]       dec_imm_sel;
  logic             waiting;
  logic             timeout_hit;
  logic             unused_instr;

  cpu_ctrl_fsm_decode u_decode (
    .opcode_i  (instr_w_i[6:0]),
    .legal_o   (legal),
    .cls_o     (cls),
    .imm_sel_o (dec_imm_sel)
  );

  assign unused_instr = ^instr_w_i[31:12];

  // Request outstanding without acknowledge; only FETCH and MEM request
  assign waiting     = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready_w_i;
  assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Wait counter restarts on every state change
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign fault_d = fault_q | (state_d == ST_FAULT);

  // Next state and datapath controls
  always_comb begin
    state_d       = state_q;
    mem_req_w_o   = 1'b0;
    mem_we_w_o    = 1'b0;
    ir_we_w_o     = 1'b0;
    pc_we_w_o     = 1'b0;
    pc_src_w_o    = PC_PLUS4;
    imm_sel_w_o   = IMM_NONE;
    alu_a_sel_w_o = 1'b0;
    alu_b_sel_w_o = 1'b0;
    alu_add_w_o   = 1'b0;
    wb_sel_w_o    = WB_ALU;
    reg_we_w_o    = 1'b0;
    fault_w_o     = fault_q;
    state_w_o     = state_q;

    case (state_q)
      ST_FETCH: begin
        mem_req_w_o = 1'b1;
        if (mem_ready_w_i) begin
          ir_we_w_o = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        imm_sel_w_o = dec_imm_sel;
        state_d     = legal ? ST_EXEC : ST_FAULT;
      end
      ST_EXEC: begin
        imm_sel_w_o   = dec_imm_sel;
        alu_a_sel_w_o = cls.auipc | cls.jal | cls.branch;
        alu_b_sel_w_o = ~cls.op;
        // LUI adds imm to a datapath-zeroed A operand
        alu_add_w_o   = cls.auipc | cls.jal | cls.branch | cls.jalr |
                        cls.load | cls.store | cls.lui;
        if (cls.branch) begin
          pc_we_w_o  = 1'b1;
          pc_src_w_o = br_taken_w_i ? PC_ALU : PC_PLUS4;
          state_d    = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        imm_sel_w_o = dec_imm_sel;
        mem_req_w_o = 1'b1;
        mem_we_w_o  = cls.store;
        if (mem_ready_w_i) begin
          if (cls.store) begin
            pc_we_w_o = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        imm_sel_w_o = dec_imm_sel;
        reg_we_w_o  = |instr_w_i[11:7];
        pc_we_w_o   = 1'b1;
        if (cls.jal) begin
          pc_src_w_o = PC_ALU;
        end else if (cls.jalr) begin
          pc_src_w_o = PC_ALU_ALIGN;
        end
        if (cls.load) begin
          wb_sel_w_o = WB_MEM;
        end else if (cls.jal || cls.jalr) begin
          wb_sel_w_o = WB_PC4;
        end
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Reset silences every output, even mid-request
    if (rst_w_i) begin
      mem_req_w_o   = 1'b0;
      mem_we_w_o    = 1'b0;
      ir_we_w_o     = 1'b0;
      pc_we_w_o     = 1'b0;
      pc_src_w_o    = '0;
      imm_sel_w_o   = '0;
      alu_a_sel_w_o = 1'b0;
      alu_b_sel_w_o = 1'b0;
      alu_add_w_o   = 1'b0;
      wb_sel_w_o    = '0;
      reg_we_w_o    = 1'b0;
      fault_w_o     = 1'b0;
      state_w_o     = '0;
    end
  end

endmodule
